seq_lock_checker: RTL and testbench

//  Parametrised digit-sequence lock checker; successor to the fixed 6-digit lock top level.

---
 rtl/seq_lock_checker.sv | 157 +++++++++++++++
 tb/tb_seq_lock_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_lock_checker.sv
// Digit-sequence lock checker. It compares strobed digits against CODE and allows up to
// MAX_ERR wrong entries. Define SEQ_LOCK_TIMEOUT_EN to enable the idle timeout.
module seq_lock_checker #(
  parameter int DIGIT_W = 4,
  parameter int CODE_LEN = 6,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 24'h590060,
  parameter int MAX_ERR = 1,
  parameter int TIMEOUT_CYC = 1000,
  localparam int PW = $clog2(CODE_LEN+1),
  localparam int EW = $clog2(MAX_ERR+2)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               insere,
  input  logic [DIGIT_W-1:0] entrada,
  input  logic               limpa,
  output logic [6:0]         display1,
  output logic               led,
  output logic               done,
  output logic [1:0]         result,
  output logic [PW-1:0]      pos,
  output logic [EW-1:0]      err_cnt
);

  typedef enum logic [1:0] {ENTRY = 2'b00, SUCCESS = 2'b01, PARTIAL = 2'b10, FAIL = 2'b11} state_t;

  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_S = 7'b1101101;
  localparam logic [6:0] GLYPH_P = 7'b1110011;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  if (CODE_LEN < 1 || MAX_ERR < 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("seq_lock_checker: invalid parameters");
  end

  function automatic logic [6:0] hex7(input logic [DIGIT_W-1:0] d);
    logic [3:0] n;
    n = 4'(d);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic               insere_q;
  logic [PW-1:0]      pos_q, pos_d;
  logic [EW-1:0]      err_q, err_d;
  logic [6:0]         disp_q, disp_d;
  logic               led_q, done_q;
  logic               accept;
  logic [CODE_LEN*DIGIT_W-1:0] code_sh;
  logic [DIGIT_W-1:0] exp_dig;

  assign accept  = insere & ~insere_q;
  // Shift the code so that the digit expected at pos_q lands in the MSBs
  assign code_sh = CODE << (pos_q * DIGIT_W);
  assign exp_dig = code_sh[CODE_LEN*DIGIT_W-1 -: DIGIT_W];

`ifdef SEQ_LOCK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC+1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    err_d   = err_q;
    disp_d  = disp_q;
`ifdef SEQ_LOCK_TIMEOUT_EN
    idle_d  = '0;
`endif
    if (limpa) begin
      state_d = ENTRY;
      pos_d   = '0;
      err_d   = '0;
      disp_d  = '0;
    end else if (state_q == ENTRY) begin
      if (accept) begin
        if (entrada == exp_dig) begin
          pos_d  = pos_q + PW'(1);
          disp_d = hex7(entrada);
          if (pos_q == PW'(CODE_LEN-1)) begin
            state_d = (err_q == '0) ? SUCCESS : PARTIAL;
            disp_d  = (err_q == '0) ? GLYPH_S : GLYPH_P;
          end
        end else begin
          err_d  = err_q + EW'(1);
          disp_d = GLYPH_E;
          if (err_q == EW'(MAX_ERR)) begin
            state_d = FAIL;
            disp_d  = GLYPH_F;
          end
        end
      end
`ifdef SEQ_LOCK_TIMEOUT_EN
      // The timer only runs once an entry has started
      else if (pos_q != '0 || err_q != '0) begin
        if (idle_q >= IW'(TIMEOUT_CYC-1)) begin
          state_d = FAIL;
          disp_d  = GLYPH_F;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ENTRY;
      insere_q <= 1'b0;
      pos_q    <= '0;
      err_q    <= '0;
      disp_q   <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_LOCK_TIMEOUT_EN
      idle_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      insere_q <= insere;
      pos_q    <= pos_d;
      err_q    <= err_d;
      disp_q   <= disp_d;
      led_q    <= (state_d == SUCCESS) || (state_d == PARTIAL);
      done_q   <= (state_d != ENTRY);
`ifdef SEQ_LOCK_TIMEOUT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign display1 = disp_q;
  assign led      = led_q;
  assign done     = done_q;
  assign result   = state_q;
  assign pos      = pos_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_seq_lock_checker.sv
// Scoreboard bench for seq_lock_checker: each task queues expected output snapshots
// {display1,result,pos,err_cnt,led,done} and compares them after the digit edge.
module tb_seq_lock_checker;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       insere = 1'b0;
  logic [3:0] entrada = '0;
  logic       limpa = 1'b0;
  logic [6:0] display1;
  logic       led, done;
  logic [1:0] result;
  logic [2:0] pos;
  logic [1:0] err_cnt;
  logic [15:0] obs;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  localparam logic [6:0] G0 = 7'b0111111, G5 = 7'b1101101, G6 = 7'b1111101, G9 = 7'b1101111;
  localparam logic [6:0] GE = 7'b1111001, GS = 7'b1101101, GP = 7'b1110011, GF = 7'b1110001;

  seq_lock_checker #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .insere(insere), .entrada(entrada), .limpa(limpa),
    .display1(display1), .led(led), .done(done), .result(result), .pos(pos), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  assign obs = {display1, result, pos, err_cnt, led, done};

  function automatic logic [15:0] mk(logic [6:0] g, logic [1:0] r, logic [2:0] p, logic [1:0] e);
    return {g, r, p, e, (r == 2'b01 || r == 2'b10), (r != 2'b00)};
  endfunction

  // One digit: high for one cycle, low for one cycle; returns on the negedge after acceptance
  task automatic pulse(input logic [3:0] d);
    @(negedge clk); insere = 1'b1; entrada = d;
    @(negedge clk); insere = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk); limpa = 1'b1;
    @(negedge clk); limpa = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(7'b0, 2'b00, 3'd0, 2'd0));
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_state: got %b want %b", obs, e); end
    reset = 1'b1;
  endtask

  task automatic test_success();
    logic [3:0] seq [6] = '{4'd5, 4'd9, 4'd0, 4'd0, 4'd6, 4'd0};
    logic [15:0] e;
    exp_q.push_back(mk(G5, 2'b00, 3'd1, 2'd0));
    exp_q.push_back(mk(G9, 2'b00, 3'd2, 2'd0));
    exp_q.push_back(mk(G0, 2'b00, 3'd3, 2'd0));
    exp_q.push_back(mk(G0, 2'b00, 3'd4, 2'd0));
    exp_q.push_back(mk(G6, 2'b00, 3'd5, 2'd0));
    exp_q.push_back(mk(GS, 2'b01, 3'd6, 2'd0));
    for (int i = 0; i < 6; i++) begin
      pulse(seq[i]);
      e = exp_q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL success step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_partial();
    logic [3:0] seq [7] = '{4'd5, 4'd8, 4'd9, 4'd0, 4'd0, 4'd6, 4'd0};
    logic [15:0] e;
    clear();
    exp_q.push_back(mk(G5, 2'b00, 3'd1, 2'd0));
    exp_q.push_back(mk(GE, 2'b00, 3'd1, 2'd1));
    exp_q.push_back(mk(G9, 2'b00, 3'd2, 2'd1));
    exp_q.push_back(mk(G0, 2'b00, 3'd3, 2'd1));
    exp_q.push_back(mk(G0, 2'b00, 3'd4, 2'd1));
    exp_q.push_back(mk(G6, 2'b00, 3'd5, 2'd1));
    exp_q.push_back(mk(GP, 2'b10, 3'd6, 2'd1));
    for (int i = 0; i < 7; i++) begin
      pulse(seq[i]);
      e = exp_q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL partial step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_fail();
    logic [3:0] seq [4] = '{4'd5, 4'd8, 4'd8, 4'd9};
    logic [15:0] e;
    clear();
    exp_q.push_back(mk(G5, 2'b00, 3'd1, 2'd0));
    exp_q.push_back(mk(GE, 2'b00, 3'd1, 2'd1));
    exp_q.push_back(mk(GF, 2'b11, 3'd1, 2'd2));
    exp_q.push_back(mk(GF, 2'b11, 3'd1, 2'd2));
    for (int i = 0; i < 4; i++) begin
      pulse(seq[i]);
      e = exp_q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL fail step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] e;
    clear();
    @(negedge clk); insere = 1'b1; entrada = 4'd5;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(G5, 2'b00, 3'd1, 2'd0));
      @(negedge clk);
      e = exp_q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL hold cycle %0d: got %b want %b", i, obs, e); end
    end
    insere = 1'b0;
    exp_q.push_back(mk(G9, 2'b00, 3'd2, 2'd0));
    pulse(4'd9);
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL hold_next: got %b want %b", obs, e); end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    clear();
    pulse(4'd5); pulse(4'd9); pulse(4'd0);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(16'd0);
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL async_reset: got %b want %b", obs, e); end
    @(negedge clk); reset = 1'b1;
    test_success();
  endtask

  task automatic test_timeout();
    logic [15:0] e;
    clear();
    exp_q.push_back(mk(G5, 2'b00, 3'd1, 2'd0));
    pulse(4'd5);
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL timeout_first: got %b want %b", obs, e); end
`ifdef SEQ_LOCK_TIMEOUT_EN
    exp_q.push_back(mk(GF, 2'b11, 3'd1, 2'd0));
`else
    exp_q.push_back(mk(G5, 2'b00, 3'd1, 2'd0));
`endif
    repeat (25) @(negedge clk);
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL timeout_idle: got %b want %b", obs, e); end
  endtask

  task automatic test_limpa_edge();
    logic [15:0] e;
    clear();
    @(negedge clk); limpa = 1'b1; insere = 1'b1; entrada = 4'd5;
    exp_q.push_back(16'd0);
    @(negedge clk); limpa = 1'b0;
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL limpa_edge: got %b want %b", obs, e); end
    exp_q.push_back(16'd0);
    @(negedge clk); insere = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front(); tests++;
    if (obs !== e) begin fails++; $display("FAIL limpa_no_late_edge: got %b want %b", obs, e); end
  endtask

  initial begin
    test_reset();
    test_success();
    test_partial();
    test_fail();
    test_hold();
    test_async_reset();
    test_timeout();
    test_limpa_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
